dh_modexp_ctrl: RTL and testbench
=================================

Name: dh_modexp_ctrl

Overview:
- Sequencer that computes R = g^x mod p by left-to-right binary square-and-multiply.
- Repeatedly drives a single-cycle multiply-then-reduce step (product mod p).
- Sits above the modular-reduction datapath in the Diffie-Hellman key-exchange flow.
- Produces both the public value (g^x mod p) and the shared secret (R_peer^x mod p), one request at a time.

Parameters:
- EXP_W, 32, exponent width in bits (number of square/multiply iterations).
- P_W, 32, modulus, base and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- g  input  P_W  base; latched when start is accepted.
- x  input  EXP_W  exponent (private key); latched when start is accepted.
- p  input  P_W  modulus; latched when start is accepted.
- busy  output  1  high while an exponentiation is in progress.
- done  output  1  one-cycle pulse when result/err are valid.
- result  output  P_W  g^x mod p; held until the next accepted start.
- err  output  1  set with done when p==0; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, done, result, err and all internal registers are 0. Asserting rst mid-operation aborts the computation with no done pulse.
- Internal state: g_l, x_l, p_l (latched inputs); base (P_W bits); acc (P_W bits); idx (clog2(EXP_W) bits).
- Each step forms a 2*P_W-bit product and reduces it in the same cycle: new = (a*b) - ((a*b)/p_l)*p_l, truncated to P_W bits.
- State IDLE:
  - start=1 is accepted on the edge (edge 1). On that edge: clear done, clear err, latch g/x/p.
  - If p==0: set err=1, result=0, done=1; stay in IDLE (busy stays 0).
  - Otherwise: base = g mod p; acc = 1 mod p (0 when p==1); idx = EXP_W-1; busy=1; go to SQR.
- State SQR: acc = acc*acc mod p_l; go to MUL.
- State MUL:
  - If x_l[idx]=1: acc = acc*base mod p_l; otherwise acc is unchanged.
  - If idx==0: result = final acc, done=1, busy=0, go to IDLE.
  - Otherwise: idx = idx-1, go to SQR.
- Fixed latency: done and result are visible after edge 2*EXP_W+1, counting the start-accepting edge as edge 1.
- busy:
  - Rises after edge 1 and falls on the same edge that raises done.
  - start while busy=1 is ignored; the in-flight inputs are unaffected.
- done:
  - High for exactly one cycle; cleared on the next edge.
  - In that done cycle the block is in IDLE, so a new start is accepted there (back-to-back operation).
- Boundary cases:
  - x==0 gives result = 1 mod p.
  - p==1 gives result = 0.
  - g >= p is legal (reduced at load).
  - g==0 with x>0 gives 0.

Optional Feature:
- Macro: MODEXP_SKIPLZ_EN.
- When defined:
  - Edge 1 goes to an added SCAN state instead of SQR.
  - In SCAN, while x_l[idx]==0 and idx>0, idx decrements once per cycle with no arithmetic.
  - Otherwise SCAN goes to SQR at the current idx.
  - Latency to done becomes EXP_W+m+3 edges, where m is the index of the highest set bit of x (m=0 when x==0).
  - Results are identical to the non-macro build.
- When undefined: no SCAN state; fixed latency 2*EXP_W+1.

Test Plan:
- g=5, x=3, p=17, EXP_W=32 -> result=6, err=0; done high after edge 65, busy high for edges 2..65. With MODEXP_SKIPLZ_EN: done after edge 36.
- g=2, x=10, p=1000 -> result=24. Separately, g=3, x=0, p=7 -> result=1. Separately, g=9, x=5, p=1 -> result=0.
- p=0, any g/x -> done and err high after edge 1, result=0, busy never rises. A following valid start clears err.
- Start g=5, x=3, p=17; pulse start again with g=2, x=10, p=1000 at edge 10 -> second request ignored, result=6. Then start in the done cycle -> accepted, result=24 after a further 65 edges.
- Assert rst at edge 20 of a run -> busy, done, result and err all 0 immediately, no done pulse. A new start after rst release computes correctly.
- Random g, x, p (p != 0), 200 iterations -> result matches a reference-model modpow, and done latency matches the formula for the current build.

Source files
------------

// File: rtl/dh_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing g^x mod p with one shared mulmod step.
// Optional leading-zero skip of the exponent is enabled by defining MODEXP_SKIPLZ_EN.
module dh_modexp_ctrl #(
    parameter int EXP_W = 32,
    parameter int P_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [P_W-1:0]   g,
    input  logic [EXP_W-1:0] x,
    input  logic [P_W-1:0]   p,
    output logic             busy,
    output logic             done,
    output logic [P_W-1:0]   result,
    output logic             err
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

`ifdef MODEXP_SKIPLZ_EN
    typedef enum logic [1:0] {IDLE, SQR, MUL, SCAN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SQR, MUL} state_t;
`endif

    state_t             state_q;
    logic [P_W-1:0]     g_q;
    logic [EXP_W-1:0]   x_q;
    logic [P_W-1:0]     p_q;
    logic [P_W-1:0]     base_q;
    logic [P_W-1:0]     acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic [P_W-1:0]     result_q;
    logic               err_q;

    logic [P_W-1:0]     mulB;
    logic [2*P_W-1:0]   prod;
    logic [P_W-1:0]     mulRes_d;
    logic [P_W-1:0]     mulAcc_d;

    // One multiplier serves both steps: squaring in SQR, multiplying by base in MUL.
    always_comb begin
        mulB     = (state_q == SQR) ? acc_q : base_q;
        prod     = {{P_W{1'b0}}, acc_q} * {{P_W{1'b0}}, mulB};
        mulRes_d = P_W'(prod % {{P_W{1'b0}}, p_q});
        mulAcc_d = x_q[idx_q] ? mulRes_d : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            x_q      <= '0;
            p_q      <= '0;
            base_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        g_q   <= g;
                        x_q   <= x;
                        p_q   <= p;
                        if (p == '0) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            base_q <= g % p;
                            acc_q  <= (p == P_W'(1)) ? '0 : P_W'(1);
                            idx_q  <= IDX_W'(EXP_W - 1);
                            busy_q <= 1'b1;
`ifdef MODEXP_SKIPLZ_EN
                            state_q <= SCAN;
`else
                            state_q <= SQR;
`endif
                        end
                    end
                end
`ifdef MODEXP_SKIPLZ_EN
                // Leading zero bits only square 1, so they are skipped without arithmetic.
                SCAN: begin
                    if (!x_q[idx_q] && idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                    end else begin
                        state_q <= SQR;
                    end
                end
`endif
                SQR: begin
                    acc_q   <= mulRes_d;
                    state_q <= MUL;
                end
                MUL: begin
                    acc_q <= mulAcc_d;
                    if (idx_q == '0) begin
                        result_q <= mulAcc_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        idx_q   <= idx_q - 1'b1;
                        state_q <= SQR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dh_modexp_ctrl.sv
// Directed and random self-checking bench for dh_modexp_ctrl (EXP_W=32, P_W=32).
// Expected latency follows MODEXP_SKIPLZ_EN when the bench is built with that macro.
module tb_dh_modexp_ctrl;

    localparam int EXP_W = 32;
    localparam int P_W   = 32;
    localparam int MAXE  = 200;

    logic             clk;
    logic             rst;
    logic             start;
    logic [P_W-1:0]   g;
    logic [EXP_W-1:0] x;
    logic [P_W-1:0]   p;
    logic             busy;
    logic             done;
    logic [P_W-1:0]   result;
    logic             err;

    int checkCount;
    int errorCount;
    int edgeCount;

    dh_modexp_ctrl #(.EXP_W(EXP_W), .P_W(P_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .g      (g),
        .x      (x),
        .p      (p),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Independent right-to-left reference using 64-bit arithmetic.
    function automatic logic [63:0] refModpow(input logic [31:0] bg, input logic [31:0] ex, input logic [31:0] md);
        logic [63:0] r, b;
        r = 64'd1 % {32'd0, md};
        b = {32'd0, bg} % {32'd0, md};
        for (int i = 0; i < 32; i++) begin
            if (ex[i]) r = (r * b) % {32'd0, md};
            b = (b * b) % {32'd0, md};
        end
        return r;
    endfunction

    function automatic int expLat(input logic [31:0] ex);
`ifdef MODEXP_SKIPLZ_EN
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) if (ex[i]) m = i;
        return EXP_W + m + 3;
`else
        return 2 * EXP_W + 1;
`endif
    endfunction

    task automatic stepEdge();
        @(posedge clk);
        #1;
        edgeCount++;
    endtask

    task automatic launch(input logic [31:0] gv, input logic [31:0] xv, input logic [31:0] pv);
        g     = gv;
        x     = xv;
        p     = pv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        edgeCount = 1;
    endtask

    task automatic waitDone(output int lat);
        while (!done && edgeCount < MAXE) stepEdge();
        if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
        lat = edgeCount;
    endtask

    // Full operation: launch, confirm busy, wait, then check result/err/latency/busy.
    task automatic applyStimulus(input string tag, input logic [31:0] gv, input logic [31:0] xv,
                                 input logic [31:0] pv, input logic [63:0] expRes);
        int lat;
        launch(gv, xv, pv);
        if (!done) checkOutput({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        waitDone(lat);
        checkOutput({tag, "_result"}, {32'd0, result}, expRes);
        checkOutput({tag, "_err"}, {63'd0, err}, 64'd0);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat(xv)));
        checkOutput({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] rg, rx, rp;
        checkCount = 0;
        errorCount = 0;
        edgeCount  = 0;
        rst   = 1'b1;
        start = 1'b0;
        g = '0; x = '0; p = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_result", {32'd0, result}, 64'd0);
        checkOutput("reset_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        stepEdge();

        applyStimulus("g5x3p17", 32'd5, 32'd3, 32'd17, 64'd6);
        stepEdge();
        checkOutput("done_one_cycle", {63'd0, done}, 64'd0);
        applyStimulus("g2x10p1000", 32'd2, 32'd10, 32'd1000, 64'd24);
        applyStimulus("x0", 32'd3, 32'd0, 32'd7, 64'd1);
        applyStimulus("p1", 32'd9, 32'd5, 32'd1, 64'd0);
        applyStimulus("g_ge_p", 32'd20, 32'd3, 32'd17, 64'd10);
        applyStimulus("g0", 32'd0, 32'd5, 32'd13, 64'd0);
        applyStimulus("xmax", 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFB, refModpow(32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFB));

        // Zero modulus: immediate error, busy never rises.
        stepEdge();
        launch(32'd4, 32'd9, 32'd0);
        checkOutput("p0_done", {63'd0, done}, 64'd1);
        checkOutput("p0_err", {63'd0, err}, 64'd1);
        checkOutput("p0_result", {32'd0, result}, 64'd0);
        checkOutput("p0_busy", {63'd0, busy}, 64'd0);
        stepEdge();
        checkOutput("p0_busy_after", {63'd0, busy}, 64'd0);
        checkOutput("p0_err_held", {63'd0, err}, 64'd1);
        applyStimulus("after_p0", 32'd5, 32'd3, 32'd17, 64'd6);

        // Start while busy is ignored; start in the done cycle is accepted.
        stepEdge();
        launch(32'd5, 32'd3, 32'd17);
        repeat (8) stepEdge();
        g = 32'd2; x = 32'd10; p = 32'd1000;
        start = 1'b1;
        stepEdge();
        start = 1'b0;
        waitDone(lat);
        checkOutput("ignore_result", {32'd0, result}, 64'd6);
        checkOutput("ignore_latency", 64'(lat), 64'(expLat(32'd3)));
        applyStimulus("back2back", 32'd2, 32'd10, 32'd1000, 64'd24);

        // Reset mid-run aborts without a done pulse.
        stepEdge();
        launch(32'd5, 32'd3, 32'd17);
        while (edgeCount < 20) stepEdge();
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_result", {32'd0, result}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        repeat (3) stepEdge();
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 70; i++) begin
            stepEdge();
            if (done) lat++;
        end
        checkOutput("rst_no_done", 64'(lat), 64'd0);
        applyStimulus("after_rst", 32'd7, 32'd13, 32'd101, refModpow(32'd7, 32'd13, 32'd101));

        for (int i = 0; i < 200; i++) begin
            rg = $urandom;
            rx = $urandom;
            rp = (i % 4 == 0) ? $urandom_range(1, 50) : $urandom;
            if (i % 8 == 1) rx = rx >> $urandom_range(0, 31);
            if (rp == 0) rp = 32'd1;
            applyStimulus("random", rg, rx, rp, refModpow(rg, rx, rp));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
